// File: rtl/block1_pool.sv
// block1_pool: 2x2 stride-2 max-pooling over 8 lockstep fp32 channels.
// Counters and control live in the top. Each channel is one lane instance
// holding its own pending pixel, its half-row line buffer and its output register.

module block1_pool_lane #(
  parameter int DW = 32,
  parameter int NB = 2,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold_we_i,
  input  logic          lb_we_i,
  input  logic          out_en_i,
  input  logic [IW-1:0] idx_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o
);

  logic [DW-1:0] h_q;
  logic [DW-1:0] lb_q [NB];
  logic [DW-1:0] out_q;
  logic [DW-1:0] p;
  logic [DW-1:0] res;

  // Bitwise fp32 max. NaN gets no special case. On a tie the function returns a.
  function automatic logic [DW-1:0] fmax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (a[DW-1] != b[DW-1])  return a[DW-1] ? b : a;
    else if (!a[DW-1])       return (b[DW-2:0] > a[DW-2:0]) ? b : a;
    else                     return (b[DW-2:0] < a[DW-2:0]) ? b : a;
  endfunction

  // Horizontal pair max, then vertical max against the buffered upper pair.
  always_comb begin
    p   = fmax(h_q, din_i);
    res = fmax(lb_q[idx_i], p);
  end

  // Holding register and line buffer. Their contents need no reset.
  always_ff @(posedge clk) begin
    if (hold_we_i) h_q <= din_i;
    if (lb_we_i)   lb_q[idx_i] <= p;
  end

  // The output register holds its value between pooled pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           out_q <= '0;
    else if (out_en_i) out_q <= res;
  end

  assign dout_o = out_q;

endmodule

module block1_pool #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 4,
  parameter int HEIGHT     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  input  logic [DATA_WIDTH-1:0] data_in_3,
  input  logic [DATA_WIDTH-1:0] data_in_4,
  input  logic [DATA_WIDTH-1:0] data_in_5,
  input  logic [DATA_WIDTH-1:0] data_in_6,
  input  logic [DATA_WIDTH-1:0] data_in_7,
  output logic [DATA_WIDTH-1:0] data_out_0,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic [DATA_WIDTH-1:0] data_out_2,
  output logic [DATA_WIDTH-1:0] data_out_3,
  output logic [DATA_WIDTH-1:0] data_out_4,
  output logic [DATA_WIDTH-1:0] data_out_5,
  output logic [DATA_WIDTH-1:0] data_out_6,
  output logic [DATA_WIDTH-1:0] data_out_7,
  output logic                  valid_out,
  output logic                  done
);

  localparam int NUM_LANES = 8;
  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int NB = WIDTH / 2;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
  // The last column or row of an odd-sized image falls outside every window.
  localparam logic [CW-1:0] PCOL_LAST = CW'(2 * NB - 1);
  localparam logic [RW-1:0] PROW_LAST = RW'(2 * (HEIGHT / 2) - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          valid_q, done_q;

  logic          last_px, active, last_pool;
  logic          hold_we, lb_we, out_en, done_d;
  logic [IW-1:0] idx;

  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] din, dout;

  assign din = {data_in_7, data_in_6, data_in_5, data_in_4,
                data_in_3, data_in_2, data_in_1, data_in_0};

  assign {data_out_7, data_out_6, data_out_5, data_out_4,
          data_out_3, data_out_2, data_out_1, data_out_0} = dout;

  // Raster position. It moves only on valid pixels and wraps at the end of an image.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid_in) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Decode which action this pixel triggers. Gaps do nothing.
  always_comb begin
    last_px   = (col_q == COL_LAST) && (row_q == ROW_LAST);
    active    = valid_in && (col_q <= PCOL_LAST) && (row_q <= PROW_LAST);
    last_pool = (col_q == PCOL_LAST) && (row_q == PROW_LAST);
    hold_we   = active && !col_q[0];
    lb_we     = active &&  col_q[0] && !row_q[0];
    out_en    = active &&  col_q[0] &&  row_q[0];
    idx       = IW'(col_q >> 1);
    done_d    = out_en && last_pool && (state_q == RUN);
  end

  // Control FSM: RUN spans one image, from its first pixel to its last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_in)            state_d = RUN;
      RUN:     if (valid_in && last_px) state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Counters, state and the registered output strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= out_en;
      done_q  <= done_d;
    end
  end

  assign valid_out = valid_q;
  assign done      = done_q;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    block1_pool_lane #(.DW(DATA_WIDTH), .NB(NB), .IW(IW)) u_lane (
      .clk       (clk),
      .rst       (reset),
      .hold_we_i (hold_we),
      .lb_we_i   (lb_we),
      .out_en_i  (out_en),
      .idx_i     (idx),
      .din_i     (din[l]),
      .dout_o    (dout[l])
    );
  end

endmodule

// File: tb/tb_block1_pool.sv
// Directed bench for block1_pool: a 4x4 instance and a 5x5 instance share the clock and reset.
module tb_block1_pool;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic v4 = 1'b0, v5 = 1'b0;
  logic [7:0][31:0] di4 = '0, di5 = '0, do4, do5;
  logic vo4, dn4, vo5, dn5;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  block1_pool #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(4)) d4 (
    .clk(clk), .reset(reset), .valid_in(v4),
    .data_in_0(di4[0]), .data_in_1(di4[1]), .data_in_2(di4[2]), .data_in_3(di4[3]),
    .data_in_4(di4[4]), .data_in_5(di4[5]), .data_in_6(di4[6]), .data_in_7(di4[7]),
    .data_out_0(do4[0]), .data_out_1(do4[1]), .data_out_2(do4[2]), .data_out_3(do4[3]),
    .data_out_4(do4[4]), .data_out_5(do4[5]), .data_out_6(do4[6]), .data_out_7(do4[7]),
    .valid_out(vo4), .done(dn4));

  block1_pool #(.DATA_WIDTH(32), .WIDTH(5), .HEIGHT(5)) d5 (
    .clk(clk), .reset(reset), .valid_in(v5),
    .data_in_0(di5[0]), .data_in_1(di5[1]), .data_in_2(di5[2]), .data_in_3(di5[3]),
    .data_in_4(di5[4]), .data_in_5(di5[5]), .data_in_6(di5[6]), .data_in_7(di5[7]),
    .data_out_0(do5[0]), .data_out_1(do5[1]), .data_out_2(do5[2]), .data_out_3(do5[3]),
    .data_out_4(do5[4]), .data_out_5(do5[5]), .data_out_6(do5[6]), .data_out_7(do5[7]),
    .valid_out(vo5), .done(dn5));

  // Exact fp32 encoding of a small non-negative integer.
  function automatic logic [31:0] fp(input int n);
    int e;
    e = 0;
    if (n == 0) return 32'h0;
    for (int b = 0; b < 24; b++) if (n[b]) e = b;
    return {1'b0, 8'(127 + e), 23'(n << (23 - e))};
  endfunction

  // Channel k carries the value n + k*mult.
  function automatic logic [7:0][31:0] ramp(input int n, input int mult);
    logic [7:0][31:0] r;
    for (int k = 0; k < 8; k++) r[k] = fp(n + k * mult);
    return r;
  endfunction

  task automatic step4(input logic v, input logic [7:0][31:0] d);
    @(negedge clk); v4 = v; di4 = d;
    @(posedge clk); #1;
  endtask

  task automatic step5(input logic v, input logic [7:0][31:0] d);
    @(negedge clk); v5 = v; di5 = d;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++; if (vo4 !== 1'b0 || dn4 !== 1'b0) begin bad++; $display("FAIL reset4 ctl got v=%b d=%b want 0 0", vo4, dn4); end
    total++; if (do4 !== '0) begin bad++; $display("FAIL reset4 data got=%h want=0", do4); end
    total++; if (vo5 !== 1'b0 || dn5 !== 1'b0) begin bad++; $display("FAIL reset5 ctl got v=%b d=%b want 0 0", vo5, dn5); end
    total++; if (do5 !== '0) begin bad++; $display("FAIL reset5 data got=%h want=0", do5); end
    @(negedge clk); reset = 1'b0;
  endtask

  // Continuous 4x4 ramp. Pulses follow indices 5,7,13,15, and done comes with the last.
  task automatic test_ramp(input int mult);
    int pos[4] = '{5, 7, 13, 15};
    int k = 0;
    logic hit;
    for (int i = 0; i < 16; i++) begin
      step4(1'b1, ramp(i, mult));
      hit = (k < 4) && (i == pos[k]);
      total++; if (vo4 !== hit) begin bad++; $display("FAIL ramp valid i=%0d got=%b want=%b", i, vo4, hit); end
      total++; if (dn4 !== (hit && k == 3)) begin bad++; $display("FAIL ramp done i=%0d got=%b want=%b", i, dn4, hit && k == 3); end
      if (hit) begin
        for (int c = 0; c < 8; c++) begin
          total++;
          if (do4[c] !== fp(i + c * mult)) begin bad++; $display("FAIL ramp data i=%0d ch=%0d got=%h want=%h", i, c, do4[c], fp(i + c * mult)); end
        end
        k++;
      end
    end
    step4(1'b0, '0);
    total++; if (vo4 !== 1'b0) begin bad++; $display("FAIL ramp tail valid got=%b want=0", vo4); end
  endtask

  // Signed windows at the top-left: {-1,-0.5,-0,-2} pools to -0, and {+0,-0,-3,-1} pools to +0.
  task automatic test_sign;
    logic [31:0] win [16];
    logic [31:0] want [2] = '{32'h80000000, 32'h00000000};
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 16; i++) win[i] = 32'h3F800000;
      if (t == 0) begin
        win[0] = 32'hBF800000; win[1] = 32'hBF000000; win[4] = 32'h80000000; win[5] = 32'hC0000000;
      end else begin
        win[0] = 32'h00000000; win[1] = 32'h80000000; win[4] = 32'hC0400000; win[5] = 32'hBF800000;
      end
      for (int i = 0; i < 16; i++) begin
        step4(1'b1, {8{win[i]}});
        if (i == 5) begin
          total++; if (vo4 !== 1'b1) begin bad++; $display("FAIL sign%0d valid got=%b want=1", t, vo4); end
          total++; if (do4[0] !== want[t]) begin bad++; $display("FAIL sign%0d ch0 got=%h want=%h", t, do4[0], want[t]); end
          total++; if (do4[7] !== want[t]) begin bad++; $display("FAIL sign%0d ch7 got=%h want=%h", t, do4[7], want[t]); end
        end
      end
    end
    step4(1'b0, '0);
  endtask

  // Three idle cycles follow every second pixel. Outputs must hold through each gap.
  task automatic test_gapped;
    int pos[4] = '{5, 7, 13, 15};
    int k = 0;
    logic hit;
    logic [31:0] hold;
    @(negedge clk); reset = 1'b1;
    #1;
    total++; if (do4[0] !== 32'h0) begin bad++; $display("FAIL gap reset got=%h want=0", do4[0]); end
    @(negedge clk); reset = 1'b0;
    hold = 32'h0;
    for (int i = 0; i < 16; i++) begin
      step4(1'b1, ramp(i, 0));
      hit = (k < 4) && (i == pos[k]);
      total++; if (vo4 !== hit) begin bad++; $display("FAIL gap valid i=%0d got=%b want=%b", i, vo4, hit); end
      if (hit) begin
        total++; if (do4[0] !== fp(i)) begin bad++; $display("FAIL gap data i=%0d got=%h want=%h", i, do4[0], fp(i)); end
        total++; if (dn4 !== (k == 3)) begin bad++; $display("FAIL gap done i=%0d got=%b want=%b", i, dn4, k == 3); end
        hold = fp(i);
        k++;
      end
      if (i % 2 == 1) begin
        for (int g = 0; g < 3; g++) begin
          step4(1'b0, ramp(999, 0));
          total++; if (vo4 !== 1'b0 || dn4 !== 1'b0) begin bad++; $display("FAIL gap idle ctl i=%0d got v=%b d=%b want 0 0", i, vo4, dn4); end
          total++; if (do4[0] !== hold) begin bad++; $display("FAIL gap hold i=%0d got=%h want=%h", i, do4[0], hold); end
        end
      end
    end
  endtask

  // Two 5x5 images back to back. Row 4 and column 4 produce no output.
  task automatic test_back_to_back;
    int pos[4] = '{6, 8, 16, 18};
    int k;
    logic hit;
    for (int img = 0; img < 2; img++) begin
      k = 0;
      for (int i = 0; i < 25; i++) begin
        step5(1'b1, ramp(i, 0));
        hit = (k < 4) && (i == pos[k]);
        total++; if (vo5 !== hit) begin bad++; $display("FAIL b2b valid img=%0d i=%0d got=%b want=%b", img, i, vo5, hit); end
        total++; if (dn5 !== (hit && k == 3)) begin bad++; $display("FAIL b2b done img=%0d i=%0d got=%b want=%b", img, i, dn5, hit && k == 3); end
        if (hit) begin
          total++; if (do5[3] !== fp(i)) begin bad++; $display("FAIL b2b data img=%0d i=%0d got=%h want=%h", img, i, do5[3], fp(i)); end
          k++;
        end
      end
    end
    step5(1'b0, '0);
    total++; if (vo5 !== 1'b0) begin bad++; $display("FAIL b2b tail valid got=%b want=0", vo5); end
  endtask

  // Reset lands between clock edges after 9 pixels. A fresh image then pools normally.
  task automatic test_reset_mid;
    for (int i = 0; i < 9; i++) step4(1'b1, ramp(i, 10));
    total++; if (do4[1] !== fp(17)) begin bad++; $display("FAIL mid pre-reset got=%h want=%h", do4[1], fp(17)); end
    #2 reset = 1'b1;
    #1;
    total++; if (vo4 !== 1'b0 || dn4 !== 1'b0) begin bad++; $display("FAIL mid async ctl got v=%b d=%b want 0 0", vo4, dn4); end
    total++; if (do4 !== '0) begin bad++; $display("FAIL mid async data got=%h want=0", do4); end
    @(negedge clk); v4 = 1'b0; reset = 1'b0;
    test_ramp(0);
  endtask

  initial begin
    test_reset;
    test_ramp(0);
    test_ramp(100);
    test_sign;
    test_gapped;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
